// File: rtl/mdu_unit_pkg.sv
// Shared types, widths and the combinational mult/div result function for the MDU.
package mdu_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [OP_W-1:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mduOp_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mduState_e;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              wr;
    } mduResult_t;

    // wr=0 marks a divide by zero: the op still occupies the unit but leaves HI/LO alone.
    function automatic mduResult_t mduCompute(input logic [OP_W-1:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        mduResult_t              r;
        logic [2*DATA_W-1:0]     prod;
        logic signed [DATA_W-1:0] sq;
        logic signed [DATA_W-1:0] sr;
        r    = '0;
        r.wr = 1'b1;
        prod = '0;
        sq   = '0;
        sr   = '0;
        case (op)
            MDU_MULT: begin
                prod = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
                r.hi = prod[2*DATA_W-1:DATA_W];
                r.lo = prod[DATA_W-1:0];
            end
            MDU_MULTU: begin
                prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
                r.hi = prod[2*DATA_W-1:DATA_W];
                r.lo = prod[DATA_W-1:0];
            end
            MDU_DIV: begin
                if (b == '0) begin
                    r.wr = 1'b0;
                end else if (a == {1'b1, {(DATA_W-1){1'b0}}} && b == '1) begin
                    // most-negative / -1 overflows; pin the architectural result explicitly
                    r.lo = a;
                    r.hi = '0;
                end else begin
                    sq   = $signed(a) / $signed(b);
                    sr   = $signed(a) % $signed(b);
                    r.lo = sq;
                    r.hi = sr;
                end
            end
            MDU_DIVU: begin
                if (b == '0) begin
                    r.wr = 1'b0;
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
            default: r.wr = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// E-stage <-> MDU bundle: op request in, launch/busy/HI/LO/read data out.
interface mdu_unit_if;
    import mdu_unit_pkg::*;

    logic [OP_W-1:0]   mdu_op;
    logic              op_valid;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              start;
    logic              busy;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output mdu_op, op_valid, src_a, src_b,
        input  start, busy, hi, lo, rd_data
    );

    modport slave (
        input  mdu_op, op_valid, src_a, src_b,
        output start, busy, hi, lo, rd_data
    );

endinterface

// File: rtl/mdu_unit.sv
// Execute-stage multiply/divide unit: fixed-latency mult/div with architectural HI/LO.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    mdu_unit_if.slave  bus
);

    mduState_e         state;
    mduState_e         stateNext;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cntLoad;
    mduResult_t        pend;
    logic [DATA_W-1:0] hiReg;
    logic [DATA_W-1:0] loReg;
    logic              busy;
    logic              isMulDiv;
    logic              isMult;
    logic              start;
    logic              launch;
    logic              commit;
    logic              writeHi;
    logic              writeLo;

    assign busy     = (state == ST_RUN);
    assign isMult   = (bus.mdu_op == MDU_MULT) || (bus.mdu_op == MDU_MULTU);
    assign isMulDiv = isMult || (bus.mdu_op == MDU_DIV) || (bus.mdu_op == MDU_DIVU);
    assign cntLoad  = isMult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: if (start) stateNext = ST_RUN;
            ST_RUN:  if (cnt == CNT_W'(1)) stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // Output/control decode; ops arriving in RUN are dropped
    always_comb begin
        start   = 1'b0;
        launch  = 1'b0;
        commit  = 1'b0;
        writeHi = 1'b0;
        writeLo = 1'b0;
        case (state)
            ST_IDLE: begin
                start   = bus.op_valid && isMulDiv;
                launch  = start;
                writeHi = bus.op_valid && (bus.mdu_op == MDU_MTHI);
                writeLo = bus.op_valid && (bus.mdu_op == MDU_MTLO);
            end
            ST_RUN: commit = (cnt == CNT_W'(1)) && pend.wr;
            default: ;
        endcase
    end

    // Pending result, latency counter and HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= '0;
            cnt   <= '0;
            hiReg <= '0;
            loReg <= '0;
        end else begin
            if (launch) begin
                pend <= mduCompute(bus.mdu_op, bus.src_a, bus.src_b);
                cnt  <= cntLoad;
            end else if (busy) begin
                cnt  <= cnt - CNT_W'(1);
            end
            if (commit) begin
                hiReg <= pend.hi;
                loReg <= pend.lo;
            end else if (writeHi) begin
                hiReg <= bus.src_a;
            end else if (writeLo) begin
                loReg <= bus.src_a;
            end
        end
    end

    assign bus.start   = start;
    assign bus.busy    = busy;
    assign bus.hi      = hiReg;
    assign bus.lo      = loReg;
    assign bus.rd_data = (bus.mdu_op == MDU_MFHI) ? hiReg :
                         (bus.mdu_op == MDU_MFLO) ? loReg : '0;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed-vector bench for mdu_unit: latency, arithmetic corners, busy-time drops, reset abort.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    mdu_unit_if busIf ();

    mdu_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks run 1 time unit later.
    task automatic drive(input logic [3:0] op, input logic v, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        busIf.mdu_op   = op;
        busIf.op_valid = v;
        busIf.src_a    = a;
        busIf.src_b    = b;
        #1;
    endtask

    task automatic idleCycle();
        drive(MDU_NONE, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic expectBusy(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            idleCycle();
            chk(tag, {31'b0, busIf.busy}, 32'd1);
        end
        idleCycle();
        chk({tag, "_end"}, {31'b0, busIf.busy}, 32'd0);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        busIf.mdu_op   = MDU_NONE;
        busIf.op_valid = 1'b0;
        busIf.src_a    = '0;
        busIf.src_b    = '0;

        idleCycle();
        idleCycle();
        chk("rst_busy",  {31'b0, busIf.busy},  32'd0);
        chk("rst_start", {31'b0, busIf.start}, 32'd0);
        chk("rst_hi",    busIf.hi, 32'h0);
        chk("rst_lo",    busIf.lo, 32'h0);
        rst_n = 1'b1;

        // signed mult: -3 * 5 = -15
        drive(MDU_MULT, 1'b1, 32'hFFFF_FFFD, 32'd5);
        chk("mult_start", {31'b0, busIf.start}, 32'd1);
        chk("mult_busy0", {31'b0, busIf.busy},  32'd0);
        idleCycle();
        chk("mult_hold_hi", busIf.hi, 32'h0);
        chk("mult_busy_1", {31'b0, busIf.busy}, 32'd1);
        expectBusy("mult_busy", 4);
        chk("mult_hi", busIf.hi, 32'hFFFF_FFFF);
        chk("mult_lo", busIf.lo, 32'hFFFF_FFF1);

        // unsigned mult then mflo
        drive(MDU_MULTU, 1'b1, 32'hFFFF_FFFF, 32'd2);
        chk("multu_start", {31'b0, busIf.start}, 32'd1);
        expectBusy("multu_busy", 5);
        chk("multu_hi", busIf.hi, 32'h0000_0001);
        chk("multu_lo", busIf.lo, 32'hFFFF_FFFE);
        drive(MDU_MFLO, 1'b1, 32'h0, 32'h0);
        chk("mflo_rd",    busIf.rd_data, 32'hFFFF_FFFE);
        chk("mflo_start", {31'b0, busIf.start}, 32'd0);
        drive(MDU_MFHI, 1'b1, 32'h0, 32'h0);
        chk("mfhi_rd", busIf.rd_data, 32'h0000_0001);
        drive(MDU_NONE, 1'b1, 32'h0, 32'h0);
        chk("none_rd", busIf.rd_data, 32'h0);

        // signed div: -7 / 2 = -3 rem -1
        drive(MDU_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("div_start", {31'b0, busIf.start}, 32'd1);
        expectBusy("div_busy", 10);
        chk("div_lo", busIf.lo, 32'hFFFF_FFFD);
        chk("div_hi", busIf.hi, 32'hFFFF_FFFF);

        // unsigned div sanity: 100 / 7 = 14 rem 2
        drive(MDU_DIVU, 1'b1, 32'd100, 32'd7);
        expectBusy("divu_busy", 10);
        chk("divu_lo", busIf.lo, 32'd14);
        chk("divu_hi", busIf.hi, 32'd2);

        // divide by zero keeps HI/LO
        drive(MDU_MTHI, 1'b1, 32'h0000_1234, 32'h0);
        drive(MDU_MTLO, 1'b1, 32'h0000_5678, 32'h0);
        chk("mthi_hi", busIf.hi, 32'h0000_1234);
        idleCycle();
        chk("mtlo_lo", busIf.lo, 32'h0000_5678);
        drive(MDU_DIVU, 1'b1, 32'd7, 32'd0);
        chk("dz_start", {31'b0, busIf.start}, 32'd1);
        expectBusy("dz_busy", 10);
        chk("dz_hi", busIf.hi, 32'h0000_1234);
        chk("dz_lo", busIf.lo, 32'h0000_5678);

        // ops while busy are dropped
        drive(MDU_MULT, 1'b1, 32'd3, 32'd4);
        chk("bz_start", {31'b0, busIf.start}, 32'd1);
        drive(MDU_MTLO, 1'b1, 32'h0000_AAAA, 32'h0);
        chk("bz_mtlo_start", {31'b0, busIf.start}, 32'd0);
        drive(MDU_MULT, 1'b1, 32'd9, 32'd9);
        chk("bz_mult_start", {31'b0, busIf.start}, 32'd0);
        chk("bz_lo_hold", busIf.lo, 32'h0000_5678);
        drive(MDU_MFHI, 1'b1, 32'h0, 32'h0);
        chk("bz_mfhi_rd", busIf.rd_data, 32'h0000_1234);
        chk("bz_busy", {31'b0, busIf.busy}, 32'd1);
        expectBusy("bz_tail", 2);
        chk("bz_lo", busIf.lo, 32'd12);
        chk("bz_hi", busIf.hi, 32'd0);
        drive(MDU_MTLO, 1'b1, 32'h0000_AAAA, 32'h0);
        idleCycle();
        chk("mtlo_after", busIf.lo, 32'h0000_AAAA);
        drive(MDU_MULT, 1'b0, 32'd3, 32'd4);
        chk("nv_start", {31'b0, busIf.start}, 32'd0);
        idleCycle();
        chk("nv_busy", {31'b0, busIf.busy}, 32'd0);
        chk("nv_lo", busIf.lo, 32'h0000_AAAA);

        // overflow divide
        drive(MDU_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        expectBusy("ovf_busy", 10);
        chk("ovf_lo", busIf.lo, 32'h8000_0000);
        chk("ovf_hi", busIf.hi, 32'h0);

        // reset mid-operation
        drive(MDU_MTHI, 1'b1, 32'h0000_BEEF, 32'h0);
        drive(MDU_DIV, 1'b1, 32'd100, 32'd7);
        chk("ra_hi_pre", busIf.hi, 32'h0000_BEEF);
        chk("ra_start",  {31'b0, busIf.start}, 32'd1);
        idleCycle();
        idleCycle();
        idleCycle();
        chk("ra_busy3", {31'b0, busIf.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ra_busy",  {31'b0, busIf.busy},  32'd0);
        chk("ra_start0",{31'b0, busIf.start}, 32'd0);
        chk("ra_hi",    busIf.hi, 32'h0);
        chk("ra_lo",    busIf.lo, 32'h0);
        idleCycle();
        rst_n = 1'b1;
        drive(MDU_MFHI, 1'b1, 32'h0, 32'h0);
        chk("ra_mfhi", busIf.rd_data, 32'h0);
        idleCycle();
        chk("ra_idle", {31'b0, busIf.busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Execute-stage multiply/divide unit with HI/LO registers for the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E and produces start/busy, which the hazard unit combines with MUL_OPD to stall D.
- Applies the fixed multi-cycle latency of the pipeline's mult/div model.
- Its read port feeds the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mdu_op  input  4  E-stage MUL_OP code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9..15 treated as none.
- op_valid  input  1  E stage holds a real instruction; low for bubble or cleared slot.
- src_a  input  32  forwarded rs value.
- src_b  input  32  forwarded rt value.
- start  output  1  combinational; launch pulse for a mult/div.
- busy  output  1  registered; operation in flight.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.
- rd_data  output  32  combinational; HI for mfhi, LO for mflo, else 0.

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, busy=0, counter=0, pending results=0.
  - start drops immediately because busy=0 and it is combinational.
  - Reset mid-operation aborts the operation; HI/LO return to 0.
- start = op_valid & ~busy & mdu_op in {1,2,3,4}.
- Launch, cycle t (start=1):
  - Result is computed from src_a/src_b and latched into pend_hi/pend_lo.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - busy goes 1 from t+1.
- States: IDLE (busy=0) and RUN (busy=1).
  - RUN decrements the counter each cycle.
  - When counter==1, the edge ending that cycle writes hi<=pend_hi, lo<=pend_lo, busy<=0.
  - Net effect: busy is high for exactly N cycles (t+1..t+N); new HI/LO are visible from cycle t+N+1.
- Arithmetic:
  - mult: signed 32x32 to 64; hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32 to 64; same split.
  - div: signed; lo=quotient truncated toward zero; hi=remainder with the dividend's sign.
  - divu: unsigned; lo=quotient, hi=remainder.
  - Divide by zero: the operation still runs the full DIV_CYCLES with busy, then leaves HI/LO unchanged.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo: when op_valid & ~busy, hi<=src_a or lo<=src_a at the next edge.
- mfhi/mflo: rd_data reads current hi/lo combinationally. No internal bypass of a same-cycle mthi; the hazard unit ordering makes that unnecessary.
- Any MDU op (1..8) arriving while busy=1 is ignored: no start, no HI/LO write, rd_data still driven. The hazard unit is responsible for never presenting such an op.
- op_valid=0: no state change; start=0.
- HI/LO are written only by commit, mthi, or mtlo, and never in the same cycle as each other.

Decomposition:
- constants.vh gains `MDU_NONE, `MDU_MULT, `MDU_MULTU, `MDU_DIV, `MDU_DIVU, `MDU_MFHI, `MDU_MFLO, `MDU_MTHI, `MDU_MTLO (4-bit). The controller and hazard unit share these codes.
- Single module: the result datapath and counter are small enough that no sub-module is warranted.
- Signed/unsigned product and quotient use Verilog operators on 64-bit/32-bit extended operands.

Test Plan:
- Reset mid-op: launch div, assert rst_n=0 at busy cycle 3 -> busy, hi, lo, and start all 0 immediately; the next mfhi returns 0.
- Signed mult: mult src_a=0xFFFFFFFD, src_b=5 -> start=1 at t, busy=1 for t+1..t+5, then hi=0xFFFFFFFF and lo=0xFFFFFFF1 from t+6.
- Unsigned mult: multu 0xFFFFFFFF x 2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles. Then mflo -> rd_data=0xFFFFFFFE.
- Signed div: div -7/2 (0xFFFFFFF9 / 2) -> busy exactly 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide by zero: after mthi 0x1234 and mtlo 0x5678, issue divu 7/0 -> busy 10 cycles, then hi=0x1234 and lo=0x5678 unchanged.
- Ops while busy: during a mult, present mtlo 0xAAAA, then a second mult, each with op_valid=1 -> start stays 0 and lo is unaffected. After busy falls, mtlo 0xAAAA -> lo=0xAAAA next cycle. op_valid=0 with mult -> no start.
